dcache: RTL and testbench

Direct-mapped, write-back data cache between the ALU and the 32-bit-block data memory. `ADDRESS` is the ALU `RESULT`, used by `lwd`/`lwi`/`swd`/`swi`. The cache returns read hits without stalling. On a miss it holds the CPU with `BUSYWAIT` while a finite-state machine (FSM) writes back any dirty victim and refills the block from memory.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/dcache_if.sv | 29 ++
 rtl/dcache_ctrl.sv | 53 +++++
 rtl/dcache.sv | 109 ++++++++++
 tb/tb_dcache.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and helpers for the direct-mapped write-back data cache.
// Address layout: tag = ADDRESS[7:5], index = ADDRESS[4:2], offset = ADDRESS[1:0].
package cache_pkg;

  localparam int TAG_W      = 3;
  localparam int IDX_W      = 3;
  localparam int OFF_W      = 2;
  localparam int BLOCK_W    = 32;
  localparam int NUM_BLOCKS = 8;
  localparam int ADDR_W     = TAG_W + IDX_W + OFF_W;
  localparam int MEM_ADDR_W = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    MEM_READ,
    UPDATE
  } state_e;

  // Byte 0 of a block lives in bits [7:0].
  function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFF_W-1:0]   off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signals of the data cache, grouped as one bus.
// The slave modport is the cache; the master modport is the CPU/memory environment.
interface dcache_if;

  logic                          READ;
  logic                          WRITE;
  logic [cache_pkg::ADDR_W-1:0]  ADDRESS;
  logic [7:0]                    WRITEDATA;
  logic [7:0]                    READDATA;
  logic                          BUSYWAIT;

  logic                              MEM_READ;
  logic                              MEM_WRITE;
  logic [cache_pkg::MEM_ADDR_W-1:0]  MEM_ADDRESS;
  logic [cache_pkg::BLOCK_W-1:0]     MEM_WRITEDATA;
  logic [cache_pkg::BLOCK_W-1:0]     MEM_READDATA;
  logic                              MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

endinterface

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM: write back a dirty victim, refill from memory, install the block.
// MEM_READ/MEM_WRITE are registered alongside the state so they are glitch-free for a whole state.
module dcache_ctrl
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req,
  input  logic   hit,
  input  logic   victim_dirty,
  input  logic   mem_busywait,
  output state_e state,
  output logic   mem_read,
  output logic   mem_write,
  output logic   busywait
);

  state_e state_q, state_d;
  logic   mem_read_q, mem_read_d;
  logic   mem_write_q, mem_write_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (req && !hit) state_d = victim_dirty ? WRITE_BACK : MEM_READ;
      WRITE_BACK: if (!mem_busywait) state_d = MEM_READ;
      MEM_READ:   if (!mem_busywait) state_d = UPDATE;
      UPDATE:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    mem_read_d  = (state_d == MEM_READ);
    mem_write_d = (state_d == WRITE_BACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // A miss stalls from the cycle it is seen, before the FSM has left IDLE.
  assign busywait  = (state_q != IDLE) || (req && !hit);
  assign state     = state_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back data cache, 8 blocks of 4 bytes, between the ALU and data memory.
// Holds the tag/data arrays, hit compare and byte select; dcache_ctrl sequences misses.
module dcache
  import cache_pkg::*;
(
  input logic     CLK,
  input logic     RESET,
  dcache_if.slave bus
);

  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_d  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_d [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    refill_q, refill_d;

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [OFF_W-1:0] addr_off;
  logic             req;
  logic             hit;
  logic             victim_dirty;
  state_e           state;
  logic             mem_read;
  logic             mem_write;
  logic             busywait;

  assign addr_off     = bus.ADDRESS[OFF_W-1:0];
  assign addr_idx     = bus.ADDRESS[OFF_W +: IDX_W];
  assign addr_tag     = bus.ADDRESS[OFF_W+IDX_W +: TAG_W];
  assign req          = bus.READ | bus.WRITE;
  assign hit          = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign victim_dirty = valid_q[addr_idx] && dirty_q[addr_idx];

  dcache_ctrl u_ctrl (
    .clk          (CLK),
    .rst          (RESET),
    .req          (req),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .mem_busywait (bus.MEM_BUSYWAIT),
    .state        (state),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .busywait     (busywait)
  );

  assign bus.BUSYWAIT  = busywait;
  assign bus.MEM_READ  = mem_read;
  assign bus.MEM_WRITE = mem_write;

  // A simultaneous READ/WRITE is treated as a store, so no load data is returned.
  always_comb begin
    bus.READDATA      = 8'h00;
    bus.MEM_ADDRESS   = '0;
    bus.MEM_WRITEDATA = '0;
    if (state == IDLE && bus.READ && !bus.WRITE && hit)
      bus.READDATA = block_byte(data_q[addr_idx], addr_off);
    if (state == WRITE_BACK) begin
      bus.MEM_ADDRESS   = {tag_q[addr_idx], addr_idx};
      bus.MEM_WRITEDATA = data_q[addr_idx];
    end else if (state == MEM_READ) begin
      bus.MEM_ADDRESS = {addr_tag, addr_idx};
    end
  end

  // Refill data is only valid in the cycle memory drops busy, so it is parked until UPDATE.
  always_comb begin
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    tag_d    = tag_q;
    data_d   = data_q;
    refill_d = refill_q;
    case (state)
      IDLE: begin
        if (bus.WRITE && hit) begin
          data_d[addr_idx][{addr_off, 3'b000} +: 8] = bus.WRITEDATA;
          dirty_d[addr_idx]                         = 1'b1;
        end
      end
      MEM_READ: begin
        if (!bus.MEM_BUSYWAIT) refill_d = bus.MEM_READDATA;
      end
      UPDATE: begin
        data_d[addr_idx]  = refill_q;
        tag_d[addr_idx]   = addr_tag;
        valid_d[addr_idx] = 1'b1;
        dirty_d[addr_idx] = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      refill_q <= refill_d;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Randomised self-checking bench for dcache: a transaction-level cache/memory model predicts
// hit/miss, stall length, load data and write-back traffic for every access.
module tb_dcache;

  logic clk;
  logic rst;
  dcache_if bus();

  dcache dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory environment: a request state lasts mem_lat cycles, busy dropping in the last one.
  logic [31:0] mem      [64];
  logic [31:0] init_img [64];
  logic        mem_load;
  int          mem_lat;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  always_comb begin
    bus.MEM_BUSYWAIT = (bus.MEM_READ && rd_cnt < mem_lat - 1) ||
                       (bus.MEM_WRITE && wr_cnt < mem_lat - 1);
    bus.MEM_READDATA = bus.MEM_READ ? mem[bus.MEM_ADDRESS] : 32'h0;
  end

  always @(posedge clk) begin
    rd_cnt <= bus.MEM_READ ? rd_cnt + 1 : 0;
    wr_cnt <= bus.MEM_WRITE ? wr_cnt + 1 : 0;
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_img[i];
    end else if (bus.MEM_WRITE && !bus.MEM_BUSYWAIT) begin
      mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
    end
  end

  // Reference model: what the cache holds and what memory should contain, byte by byte.
  logic       m_valid [8];
  logic       m_dirty [8];
  logic [2:0] m_tag   [8];
  logic [7:0] m_line  [8][4];
  logic [7:0] ref_mem [64][4];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input  logic        rd,
                                input  logic        wr,
                                input  logic [7:0]  addr,
                                input  logic [7:0]  wdata,
                                output int          stall,
                                output int          rd_cyc,
                                output logic [7:0]  rdata,
                                output logic [5:0]  rd_addr,
                                output logic [5:0]  wb_addr,
                                output logic [31:0] wb_data);
    logic [2:0] idx;
    logic [2:0] tg;
    logic [1:0] off;
    logic       hit;
    logic       vdirty;
    logic [7:0] line [4];
    logic [7:0] exp_rdata;
    int         exp_stall;
    int         cycles;
    int         wr_cyc;
    int         both;
    logic       busy0;

    idx    = addr[4:2];
    tg     = addr[7:5];
    off    = addr[1:0];
    hit    = m_valid[idx] && (m_tag[idx] == tg);
    vdirty = !hit && m_valid[idx] && m_dirty[idx];
    if (hit) line = m_line[idx];
    else for (int b = 0; b < 4; b++) line[b] = ref_mem[addr[7:2]][b];
    exp_rdata = (rd && !wr) ? line[off] : 8'h00;
    exp_stall = hit ? 0 : (vdirty ? 2 * mem_lat + 1 : mem_lat + 1);

    bus.READ      = rd;
    bus.WRITE     = wr;
    bus.ADDRESS   = addr;
    bus.WRITEDATA = wdata;

    @(negedge clk);
    busy0 = bus.BUSYWAIT;
    check_output("busy_on_issue", {31'b0, busy0}, {31'b0, !hit});
    cycles  = 0;
    rd_cyc  = 0;
    wr_cyc  = 0;
    both    = 0;
    rd_addr = '0;
    wb_addr = '0;
    wb_data = '0;
    while (bus.BUSYWAIT && cycles < 200) begin
      check_output("rdata_while_busy", {24'b0, bus.READDATA}, 32'h0);
      if (bus.MEM_READ) begin
        rd_cyc++;
        rd_addr = bus.MEM_ADDRESS;
      end
      if (bus.MEM_WRITE) begin
        wr_cyc++;
        wb_addr = bus.MEM_ADDRESS;
        wb_data = bus.MEM_WRITEDATA;
      end
      if (bus.MEM_READ && bus.MEM_WRITE) both++;
      @(negedge clk);
      cycles++;
    end
    if (bus.BUSYWAIT) begin
      checks++;
      failures++;
      $display("[TB] FAIL busy_timeout: addr %h still stalled after %0d cycles", addr, cycles);
    end
    stall = cycles - (busy0 ? 1 : 0);
    rdata = bus.READDATA;

    check_output("stall_cycles", stall, exp_stall);
    check_output("readdata", {24'b0, rdata}, {24'b0, exp_rdata});
    check_output("mem_read_cycles", rd_cyc, hit ? 0 : mem_lat);
    check_output("mem_write_cycles", wr_cyc, vdirty ? mem_lat : 0);
    check_output("mem_rd_wr_overlap", both, 0);
    check_output("mem_idle_at_done", {30'b0, bus.MEM_READ, bus.MEM_WRITE}, 32'h0);
    if (!hit) check_output("refill_addr", {26'b0, rd_addr}, {26'b0, addr[7:2]});
    if (vdirty) begin
      check_output("wb_addr", {26'b0, wb_addr}, {26'b0, m_tag[idx], idx});
      check_output("wb_data", wb_data,
                   {m_line[idx][3], m_line[idx][2], m_line[idx][1], m_line[idx][0]});
    end

    @(posedge clk);
    if (!hit) begin
      if (vdirty) for (int b = 0; b < 4; b++) ref_mem[{m_tag[idx], idx}][b] = m_line[idx][b];
      m_line[idx]  = line;
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_line[idx][off] = wdata;
      m_dirty[idx]     = 1'b1;
    end
    #1;
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  initial begin
    int          stall;
    int          rdc;
    logic [7:0]  rdata;
    logic [5:0]  rda;
    logic [5:0]  wba;
    logic [31:0] wbd;

    for (int i = 0; i < 64; i++) begin
      init_img[i] = $urandom;
      if (i == 9) init_img[i] = 32'hDDCCBBAA;
      for (int b = 0; b < 4; b++) ref_mem[i][b] = init_img[i][8*b +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      for (int b = 0; b < 4; b++) m_line[i][b] = '0;
    end
    mem_lat       = 5;
    mem_load      = 1'b1;
    rst           = 1'b1;
    bus.READ      = 1'b0;
    bus.WRITE     = 1'b0;
    bus.ADDRESS   = '0;
    bus.WRITEDATA = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_busywait", {31'b0, bus.BUSYWAIT}, 32'h0);
    check_output("rst_readdata", {24'b0, bus.READDATA}, 32'h0);
    check_output("rst_mem_read", {31'b0, bus.MEM_READ}, 32'h0);
    check_output("rst_mem_write", {31'b0, bus.MEM_WRITE}, 32'h0);
    check_output("rst_mem_address", {26'b0, bus.MEM_ADDRESS}, 32'h0);
    check_output("rst_mem_writedata", bus.MEM_WRITEDATA, 32'h0);
    rst      = 1'b0;
    mem_load = 1'b0;
    @(posedge clk);
    #1;

    // Clean miss, then hits on the refilled block.
    apply_stimulus(1'b1, 1'b0, 8'h24, 8'h00, stall, rdc, rdata, rda, wba, wbd);
    check_output("lit_miss_rdata", {24'b0, rdata}, 32'hAA);
    check_output("lit_miss_stall", stall, 6);
    check_output("lit_miss_memread", rdc, 5);
    apply_stimulus(1'b1, 1'b0, 8'h27, 8'h00, stall, rdc, rdata, rda, wba, wbd);
    check_output("lit_hit_rdata", {24'b0, rdata}, 32'hDD);
    check_output("lit_hit_stall", stall, 0);
    apply_stimulus(1'b0, 1'b1, 8'h25, 8'h5A, stall, rdc, rdata, rda, wba, wbd);
    check_output("lit_store_stall", stall, 0);
    apply_stimulus(1'b1, 1'b0, 8'h25, 8'h00, stall, rdc, rdata, rda, wba, wbd);
    check_output("lit_store_readback", {24'b0, rdata}, 32'h5A);
    check_output("lit_mem_untouched", mem[9], 32'hDDCCBBAA);

    // Conflict miss on index 1 evicts the dirty block.
    apply_stimulus(1'b1, 1'b0, 8'hE4, 8'h00, stall, rdc, rdata, rda, wba, wbd);
    check_output("lit_wb_addr", {26'b0, wba}, 32'h09);
    check_output("lit_wb_data", wbd, 32'hDDCC5AAA);
    check_output("lit_refill_addr", {26'b0, rda}, 32'h39);
    check_output("lit_dirty_stall", stall, 11);

    // READ and WRITE together on a hit behave as a store.
    apply_stimulus(1'b1, 1'b1, 8'hE5, 8'h77, stall, rdc, rdata, rda, wba, wbd);
    check_output("lit_rw_rdata", {24'b0, rdata}, 32'h0);
    apply_stimulus(1'b1, 1'b0, 8'h24, 8'h00, stall, rdc, rdata, rda, wba, wbd);
    check_output("lit_rw_wb_addr", {26'b0, wba}, 32'h39);
    check_output("lit_rw_wb_byte", {24'b0, wbd[15:8]}, 32'h77);

    // Reset during a refill abandons it and invalidates every line.
    bus.READ    = 1'b1;
    bus.ADDRESS = 8'h48;
    @(negedge clk);
    check_output("mid_rst_issue_busy", {31'b0, bus.BUSYWAIT}, 32'h1);
    repeat (2) @(negedge clk);
    check_output("mid_rst_in_memread", {31'b0, bus.MEM_READ}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("mid_rst_memread_drop", {31'b0, bus.MEM_READ}, 32'h0);
    check_output("mid_rst_memwrite_low", {31'b0, bus.MEM_WRITE}, 32'h0);
    check_output("mid_rst_still_miss", {31'b0, bus.BUSYWAIT}, 32'h1);
    bus.READ = 1'b0;
    #1;
    check_output("mid_rst_idle", {31'b0, bus.BUSYWAIT}, 32'h0);
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b0, 8'h48, 8'h00, stall, rdc, rdata, rda, wba, wbd);
    check_output("lit_after_rst_stall", stall, 6);
    apply_stimulus(1'b1, 1'b0, 8'h24, 8'h00, stall, rdc, rdata, rda, wba, wbd);

    // Random traffic over a few tags per index so hits, clean and dirty misses all occur.
    for (int n = 0; n < 150; n++) begin
      logic [7:0] a;
      int         op;
      mem_lat = $urandom_range(1, 4);
      a       = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op      = $urandom_range(0, 3);
      apply_stimulus(op != 2, op >= 2, a, 8'($urandom), stall, rdc, rdata, rda, wba, wbd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
